// File: rtl/trisc_pkg.sv
// Shared encodings for the TRISC control sequencer and datapath.
package trisc_pkg;

    // Sequencer states; values are visible on the State debug port.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_F2   = 3'd3,
        ST_DEC  = 3'd4,
        ST_E0   = 3'd5,
        ST_E1   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    // ALU function select driven alongside ACC_ld.
    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_XOR  = 2'b11
    } alu_op_t;

    // Priority-resolved instruction; OP_NOP covers unused opcodes.
    typedef enum logic [3:0] {
        OP_NOP,
        OP_LDA,
        OP_STA,
        OP_ADD,
        OP_SUB,
        OP_XOR,
        OP_INC,
        OP_CLR,
        OP_JMP,
        OP_JPZ,
        OP_JPN,
        OP_HLT
    } opcode_t;

    // dec = {LDA,STA,ADD,SUB,XOR,INC,CLR,JMP,JPZ,JPN,HLT}; MSB wins.
    function automatic opcode_t resolve_op(input logic [10:0] dec);
        if (dec[10])     return OP_LDA;
        else if (dec[9]) return OP_STA;
        else if (dec[8]) return OP_ADD;
        else if (dec[7]) return OP_SUB;
        else if (dec[6]) return OP_XOR;
        else if (dec[5]) return OP_INC;
        else if (dec[4]) return OP_CLR;
        else if (dec[3]) return OP_JMP;
        else if (dec[2]) return OP_JPZ;
        else if (dec[1]) return OP_JPN;
        else if (dec[0]) return OP_HLT;
        else             return OP_NOP;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the datapath.
interface control_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             Run;
    logic             LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
    logic             Z, N;
    logic             MAR_ld_pc, MAR_ld_ir, Mem_rd, Mem_wr, MDR_ld_acc, IR_ld;
    logic             PC_inc, PC_ld, ACC_ld, ACC_clr, ACC_inc;
    logic [1:0]       ALU_op;
    logic             Halted;
    logic [2:0]       State;
    logic [CNT_W-1:0] InstrCnt;

    // Sequencer side: consumes decode/flags, drives strobes.
    modport master (
        input  Run, LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT, Z, N,
        output MAR_ld_pc, MAR_ld_ir, Mem_rd, Mem_wr, MDR_ld_acc, IR_ld,
               PC_inc, PC_ld, ACC_ld, ACC_clr, ACC_inc, ALU_op, Halted, State, InstrCnt
    );

    // Datapath side: drives decode/flags, consumes strobes.
    modport slave (
        output Run, LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT, Z, N,
        input  MAR_ld_pc, MAR_ld_ir, Mem_rd, Mem_wr, MDR_ld_acc, IR_ld,
               PC_inc, PC_ld, ACC_ld, ACC_clr, ACC_inc, ALU_op, Halted, State, InstrCnt
    );

endinterface

// File: rtl/control_sequencer.sv
// TRISC control sequencer: fetch/decode/execute FSM with Mealy datapath strobes
// and a retired-instruction counter.
module control_sequencer
    import trisc_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic             LDA,
    input  logic             STA,
    input  logic             ADD,
    input  logic             SUB,
    input  logic             XOR,
    input  logic             INC,
    input  logic             CLR,
    input  logic             JMP,
    input  logic             JPZ,
    input  logic             JPN,
    input  logic             HLT,
    input  logic             Z,
    input  logic             N,
    output logic             MAR_ld_pc,
    output logic             MAR_ld_ir,
    output logic             Mem_rd,
    output logic             Mem_wr,
    output logic             MDR_ld_acc,
    output logic             IR_ld,
    output logic             PC_inc,
    output logic             PC_ld,
    output logic             ACC_ld,
    output logic             ACC_clr,
    output logic             ACC_inc,
    output logic [1:0]       ALU_op,
    output logic             Halted,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstrCnt
);

    state_t  state, next_state;
    opcode_t op;
    logic    retire;

    assign op     = resolve_op({LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT});
    assign State  = state;
    assign Halted = (state == ST_HALT);

    // Next state, strobes and retire pulse from one case on the current state.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        MAR_ld_pc  = 1'b0;
        MAR_ld_ir  = 1'b0;
        Mem_rd     = 1'b0;
        Mem_wr     = 1'b0;
        MDR_ld_acc = 1'b0;
        IR_ld      = 1'b0;
        PC_inc     = 1'b0;
        PC_ld      = 1'b0;
        ACC_ld     = 1'b0;
        ACC_clr    = 1'b0;
        ACC_inc    = 1'b0;
        ALU_op     = ALU_PASS;
        case (state)
            ST_IDLE: if (Run) next_state = ST_F0;
            ST_F0: begin
                MAR_ld_pc  = 1'b1;
                next_state = ST_F1;
            end
            ST_F1: begin
                Mem_rd     = 1'b1;
                PC_inc     = 1'b1;
                next_state = ST_F2;
            end
            ST_F2: begin
                IR_ld      = 1'b1;
                next_state = ST_DEC;
            end
            ST_DEC: begin
                // Every DEC exit retires except the hand-off to the memory phase.
                retire     = 1'b1;
                next_state = ST_F0;
                case (op)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_XOR: begin
                        MAR_ld_ir  = 1'b1;
                        retire     = 1'b0;
                        next_state = ST_E0;
                    end
                    OP_INC:  ACC_inc = 1'b1;
                    OP_CLR:  ACC_clr = 1'b1;
                    OP_JMP:  PC_ld   = 1'b1;
                    OP_JPZ:  PC_ld   = Z;
                    OP_JPN:  PC_ld   = N;
                    OP_HLT:  next_state = ST_HALT;
                    default: ;
                endcase
            end
            ST_E0: begin
                next_state = ST_E1;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_XOR: Mem_rd     = 1'b1;
                    OP_STA:                         MDR_ld_acc = 1'b1;
                    default: ;
                endcase
            end
            ST_E1: begin
                retire     = 1'b1;
                next_state = ST_F0;
                case (op)
                    OP_LDA: begin ACC_ld = 1'b1; ALU_op = ALU_PASS; end
                    OP_ADD: begin ACC_ld = 1'b1; ALU_op = ALU_ADD;  end
                    OP_SUB: begin ACC_ld = 1'b1; ALU_op = ALU_SUB;  end
                    OP_XOR: begin ACC_ld = 1'b1; ALU_op = ALU_XOR;  end
                    OP_STA: Mem_wr = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_IDLE;
        endcase
    end

    // State register and wrapping retired-instruction counter.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= ST_IDLE;
            InstrCnt <= '0;
        end else begin
            state <= next_state;
            if (retire) InstrCnt <= InstrCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

    localparam logic [10:0] D_LDA = 11'h400, D_STA = 11'h200, D_ADD = 11'h100,
                            D_SUB = 11'h080, D_XOR = 11'h040, D_INC = 11'h020,
                            D_CLR = 11'h010, D_JMP = 11'h008, D_JPZ = 11'h004,
                            D_JPN = 11'h002, D_HLT = 11'h001;

    // Strobe vector bit weights: {MAR_ld_pc,MAR_ld_ir,Mem_rd,Mem_wr,MDR_ld_acc,
    // IR_ld,PC_inc,PC_ld,ACC_ld,ACC_clr,ACC_inc}
    localparam logic [10:0] S_NONE = 11'h000, S_MARPC = 11'h400, S_MARIR = 11'h200,
                            S_RD = 11'h100, S_WR = 11'h080, S_MDR = 11'h040,
                            S_IR = 11'h020, S_PCINC = 11'h010, S_PCLD = 11'h008,
                            S_ACCLD = 11'h004, S_CLR = 11'h002, S_INC = 11'h001;

    logic        clk;
    logic        rstn;
    int          tests;
    int          fails;
    logic [10:0] strobes;

    control_sequencer_if #(.CNT_W(8)) bus ();

    control_sequencer #(.CNT_W(8)) dut (
        .Clock(clk), .Resetn(rstn), .Run(bus.Run),
        .LDA(bus.LDA), .STA(bus.STA), .ADD(bus.ADD), .SUB(bus.SUB), .XOR(bus.XOR),
        .INC(bus.INC), .CLR(bus.CLR), .JMP(bus.JMP), .JPZ(bus.JPZ), .JPN(bus.JPN),
        .HLT(bus.HLT), .Z(bus.Z), .N(bus.N),
        .MAR_ld_pc(bus.MAR_ld_pc), .MAR_ld_ir(bus.MAR_ld_ir), .Mem_rd(bus.Mem_rd),
        .Mem_wr(bus.Mem_wr), .MDR_ld_acc(bus.MDR_ld_acc), .IR_ld(bus.IR_ld),
        .PC_inc(bus.PC_inc), .PC_ld(bus.PC_ld), .ACC_ld(bus.ACC_ld),
        .ACC_clr(bus.ACC_clr), .ACC_inc(bus.ACC_inc), .ALU_op(bus.ALU_op),
        .Halted(bus.Halted), .State(bus.State), .InstrCnt(bus.InstrCnt)
    );

    assign strobes = {bus.MAR_ld_pc, bus.MAR_ld_ir, bus.Mem_rd, bus.Mem_wr, bus.MDR_ld_acc,
                      bus.IR_ld, bus.PC_inc, bus.PC_ld, bus.ACC_ld, bus.ACC_clr, bus.ACC_inc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] strb,
                       input logic [1:0] alu);
        tick();
        chk({tag, ".state"}, 32'(bus.State), 32'(st));
        chk({tag, ".strobes"}, 32'(strobes), 32'(strb));
        chk({tag, ".alu"}, 32'(bus.ALU_op), 32'(alu));
    endtask

    task automatic set_op(input logic [10:0] d);
        {bus.LDA, bus.STA, bus.ADD, bus.SUB, bus.XOR, bus.INC, bus.CLR,
         bus.JMP, bus.JPZ, bus.JPN, bus.HLT} = d;
    endtask

    // From F0: F1 and F2 of the fetch.
    task automatic fetch(input string tag);
        cyc({tag, ".F1"}, 3'd2, S_RD | S_PCINC, 2'b00);
        cyc({tag, ".F2"}, 3'd3, S_IR, 2'b00);
    endtask

    task automatic mem_instr(input string tag, input logic [10:0] d, input logic [10:0] e0,
                             input logic [10:0] e1, input logic [1:0] alu, input int cnt);
        set_op(d);
        fetch(tag);
        cyc({tag, ".DEC"}, 3'd4, S_MARIR, 2'b00);
        cyc({tag, ".E0"}, 3'd5, e0, 2'b00);
        cyc({tag, ".E1"}, 3'd6, e1, alu);
        cyc({tag, ".F0"}, 3'd1, S_MARPC, 2'b00);
        chk({tag, ".cnt"}, 32'(bus.InstrCnt), 32'(cnt));
    endtask

    task automatic short_instr(input string tag, input logic [10:0] d, input logic [10:0] ds,
                               input int cnt);
        set_op(d);
        fetch(tag);
        cyc({tag, ".DEC"}, 3'd4, ds, 2'b00);
        cyc({tag, ".F0"}, 3'd1, S_MARPC, 2'b00);
        chk({tag, ".cnt"}, 32'(bus.InstrCnt), 32'(cnt));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        bus.Run = 1'b0;
        bus.Z = 1'b0;
        bus.N = 1'b0;
        set_op(11'h000);

        // Reset state
        tick();
        cyc("rst", 3'd0, S_NONE, 2'b00);
        chk("rst.cnt", 32'(bus.InstrCnt), 32'd0);
        chk("rst.halted", 32'(bus.Halted), 32'd0);

        // IDLE holds without Run
        rstn = 1'b1;
        cyc("idle", 3'd0, S_NONE, 2'b00);
        cyc("idle2", 3'd0, S_NONE, 2'b00);

        // LDA from reset: 0,1,2,3,4,5,6,1
        bus.Run = 1'b1;
        set_op(D_LDA);
        cyc("lda.F0", 3'd1, S_MARPC, 2'b00);
        bus.Run = 1'b0;
        mem_instr("lda", D_LDA, S_RD, S_ACCLD, 2'b00, 1);
        mem_instr("add", D_ADD, S_RD, S_ACCLD, 2'b01, 2);
        mem_instr("sub", D_SUB, S_RD, S_ACCLD, 2'b10, 3);
        mem_instr("xor", D_XOR, S_RD, S_ACCLD, 2'b11, 4);
        mem_instr("sta", D_STA, S_MDR, S_WR, 2'b00, 5);

        // Conditional and unconditional jumps, accumulator ops, NOP
        bus.Z = 1'b0;
        short_instr("jpz0", D_JPZ, S_NONE, 6);
        bus.Z = 1'b1;
        short_instr("jpz1", D_JPZ, S_PCLD, 7);
        bus.Z = 1'b0;
        bus.N = 1'b0;
        short_instr("jpn0", D_JPN, S_NONE, 8);
        bus.N = 1'b1;
        short_instr("jpn1", D_JPN, S_PCLD, 9);
        bus.N = 1'b0;
        short_instr("jmp", D_JMP, S_PCLD, 10);
        short_instr("inc", D_INC, S_INC, 11);
        short_instr("clr", D_CLR, S_CLR, 12);
        short_instr("nop", 11'h000, S_NONE, 13);

        // Priority between simultaneous decode lines
        mem_instr("pri_lda_hlt", D_LDA | D_HLT, S_RD, S_ACCLD, 2'b00, 14);
        short_instr("pri_inc_clr_jmp", D_INC | D_CLR | D_JMP, S_INC, 15);
        mem_instr("pri_sta_add", D_STA | D_ADD, S_MDR, S_WR, 2'b00, 16);

        // Reset in E0 of ADD
        set_op(D_ADD);
        fetch("add_rst");
        cyc("add_rst.DEC", 3'd4, S_MARIR, 2'b00);
        cyc("add_rst.E0", 3'd5, S_RD, 2'b00);
        rstn = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            cyc("add_rst.after", 3'd0, S_NONE, 2'b00);
            chk("add_rst.cnt", 32'(bus.InstrCnt), 32'd0);
        end

        // 256 INC instructions: counter wraps to 0
        rstn = 1'b1;
        bus.Run = 1'b1;
        set_op(D_INC);
        cyc("wrap.F0", 3'd1, S_MARPC, 2'b00);
        bus.Run = 1'b0;
        for (int unsigned i = 0; i < 255; i++) begin
            repeat (4) @(posedge clk);
        end
        #1;
        chk("wrap.cnt255", 32'(bus.InstrCnt), 32'd255);
        chk("wrap.state255", 32'(bus.State), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("wrap.cnt256", 32'(bus.InstrCnt), 32'd0);
        chk("wrap.state256", 32'(bus.State), 32'd1);

        // HLT then Run toggling; only reset leaves HALT
        set_op(D_HLT);
        fetch("hlt");
        cyc("hlt.DEC", 3'd4, S_NONE, 2'b00);
        cyc("hlt.HALT", 3'd7, S_NONE, 2'b00);
        chk("hlt.halted", 32'(bus.Halted), 32'd1);
        chk("hlt.cnt", 32'(bus.InstrCnt), 32'd1);
        for (int unsigned i = 0; i < 20; i++) begin
            bus.Run = ~bus.Run;
            tick();
            chk("hlt.hold", 32'(bus.State), 32'd7);
        end
        rstn = 1'b0;
        tick();
        chk("hlt_rst.state", 32'(bus.State), 32'd0);
        chk("hlt_rst.cnt", 32'(bus.InstrCnt), 32'd0);
        chk("hlt_rst.halted", 32'(bus.Halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
